// File: rtl/core_sequencer.sv
// core_sequencer: run-control stage in front of the processor core.
// Loads an input block into the shared data memory while the core is held in
// reset, releases the core until it signals done (or a run-cycle limit hits),
// then streams the result region back out and returns to idle.
module core_sequencer #(
   parameter int unsigned AW       = 8,
   parameter int unsigned IN_BASE  = 0,
   parameter int unsigned IN_LEN   = 60,
   parameter int unsigned OUT_BASE = 64,
   parameter int unsigned OUT_LEN  = 60,
   parameter int unsigned TMO_W    = 20,
   parameter int unsigned TIMEOUT  = 1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   output logic             core_reset,
   input  logic             core_done,
   output logic             mem_own,
   output logic             mem_wr_en,
   output logic [AW-1:0]    mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   output logic             busy,
   output logic             complete,
   output logic             timeout_err,
   output logic [TMO_W-1:0] run_cycles
);

   // Index must reach the larger of the two block lengths minus one.
   localparam int unsigned MAX_LEN = (IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN;
   localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   index_q;
   logic [TMO_W-1:0]   cnt_q;
   logic [TMO_W-1:0]   run_cycles_q;
   logic               timeout_err_q;
   logic               core_reset_q;
   logic               mem_own_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic               complete_q;

   logic               in_fire;
   logic               out_fire;
   logic [AW-1:0]      in_addr;
   logic [AW-1:0]      out_addr;

   // Handshakes and wrapping memory addresses derived from the index register.
   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;
   assign in_addr  = AW'(IN_BASE) + AW'(index_q);
   assign out_addr = AW'(OUT_BASE) + AW'(index_q);

   // Memory port: writes land in the same cycle as the input handshake, and
   // the drain address only moves on an output handshake so data stays stable.
   assign mem_wr_en = in_fire;
   assign mem_wdata = in_data;
   assign mem_addr  = (state_q == S_DRAIN) ? out_addr : in_addr;
   assign out_data  = mem_rdata;

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign core_reset  = core_reset_q;
   assign mem_own     = mem_own_q;
   assign busy        = busy_q;
   assign complete    = complete_q;
   assign timeout_err = timeout_err_q;
   assign run_cycles  = run_cycles_q;

   // Job sequencing FSM; registered outputs are updated on each transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         index_q       <= '0;
         cnt_q         <= '0;
         run_cycles_q  <= '0;
         timeout_err_q <= 1'b0;
         core_reset_q  <= 1'b1;
         mem_own_q     <= 1'b1;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         complete_q    <= 1'b0;
      end else begin
         complete_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_LOAD;
                  index_q       <= '0;
                  timeout_err_q <= 1'b0;
                  in_ready_q    <= 1'b1;
                  busy_q        <= 1'b1;
               end
            end
            S_LOAD: begin
               if (in_fire) begin
                  if (index_q == IDX_W'(IN_LEN - 1)) begin
                     state_q      <= S_RUN;
                     index_q      <= '0;
                     cnt_q        <= '0;
                     in_ready_q   <= 1'b0;
                     core_reset_q <= 1'b0;
                     mem_own_q    <= 1'b0;
                  end else begin
                     index_q <= index_q + IDX_W'(1);
                  end
               end
            end
            S_RUN: begin
               // done takes priority over a coincident timeout
               if (core_done) begin
                  state_q      <= S_DRAIN;
                  run_cycles_q <= cnt_q;
                  index_q      <= '0;
                  core_reset_q <= 1'b1;
                  mem_own_q    <= 1'b1;
                  out_valid_q  <= 1'b1;
               end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                  state_q       <= S_FINISH;
                  run_cycles_q  <= TMO_W'(TIMEOUT);
                  timeout_err_q <= 1'b1;
                  core_reset_q  <= 1'b1;
                  mem_own_q     <= 1'b1;
                  complete_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + TMO_W'(1);
               end
            end
            S_DRAIN: begin
               if (out_fire) begin
                  if (index_q == IDX_W'(OUT_LEN - 1)) begin
                     state_q     <= S_FINISH;
                     out_valid_q <= 1'b0;
                     complete_q  <= 1'b1;
                  end else begin
                     index_q <= index_q + IDX_W'(1);
                  end
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q      <= S_IDLE;
               core_reset_q <= 1'b1;
               mem_own_q    <= 1'b1;
               in_ready_q   <= 1'b0;
               out_valid_q  <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Run-control stage directly upstream of the processor core. The core contributes its done flag and shares its data memory.
- Holds the core in reset and streams an input block into data memory over a valid/ready port.
- Releases the core and waits for done, or times out.
- Streams the result region back out over a second valid/ready port, then returns to idle for the next job.

Parameters:
- AW, 8: data memory address width.
- IN_BASE, 0: first memory address written during LOAD.
- IN_LEN, 60: bytes loaded per job; must be ≥1.
- OUT_BASE, 64: first memory address read during DRAIN.
- OUT_LEN, 60: bytes drained per job; must be ≥1.
- TMO_W, 20: width of the run-cycle counter.
- TIMEOUT, 1000000: number of RUN cycles without done before abort; must be < 2^TMO_W.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: job request; sampled only in IDLE.
- in_valid, input, 1: input byte valid.
- in_data, input, 8: input byte.
- in_ready, output, 1: sequencer accepts input byte.
- out_valid, output, 1: result byte valid.
- out_data, output, 8: result byte.
- out_ready, input, 1: consumer accepts result byte.
- core_reset, output, 1: drives the core's reset input.
- core_done, input, 1: core done flag.
- mem_own, output, 1: 1 = sequencer drives the data memory port; 0 = core drives it (external mux select).
- mem_wr_en, output, 1: memory write enable.
- mem_addr, output, AW: memory address.
- mem_wdata, output, 8: memory write data.
- mem_rdata, input, 8: memory read data; combinational from mem_addr.
- busy, output, 1: high in every state except IDLE.
- complete, output, 1: one-cycle pulse when a job ends.
- timeout_err, output, 1: last job aborted on timeout.
- run_cycles, output, TMO_W: latched RUN length of the last job.

Behaviour:
- Reset, synchronous: state=IDLE, core_reset=1, mem_own=1, mem_wr_en=0, in_ready=0, out_valid=0, busy=0, complete=0, timeout_err=0, run_cycles=0, index=0. A reset mid-job aborts immediately to IDLE. No output pulse is produced and memory contents are left as-is.
- States: IDLE, LOAD, RUN, DRAIN, FINISH (one-hot or binary; encoding not visible).
- IDLE:
  - core_reset=1, mem_own=1.
  - On start=1: clear index, clear timeout_err, go to LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mem_wr_en=1 that cycle, mem_addr=IN_BASE+index, mem_wdata=in_data, index++.
  - On the write with index==IN_LEN-1: go to RUN, clear index and the cycle counter.
  - No write occurs in cycles where in_valid=0.
- RUN:
  - core_reset=0, mem_own=0, in_ready=0, mem_wr_en=0.
  - Counter increments each cycle core_done=0.
  - If core_done=1: latch run_cycles=counter, go to DRAIN, drive core_reset=1 from that transition onward.
  - Else if counter==TIMEOUT-1: set timeout_err=1, latch run_cycles=TIMEOUT, go to FINISH with no drain.
  - If core_done and the timeout coincide, core_done wins.
  - core_done is ignored outside RUN.
- Core reset and memory:
  - Core reset clears only core state (PC, registers, flags); data memory is not cleared.
  - The core's first fetch is the cycle after core_reset falls.
- DRAIN:
  - core_reset=1, mem_own=1.
  - mem_addr=OUT_BASE+index.
  - out_valid=1, out_data=mem_rdata.
  - Address changes only on a handshake, so out_data is stable while out_valid&!out_ready.
  - On out_valid&out_ready: index++; after byte OUT_LEN-1 go to FINISH.
- FINISH:
  - complete=1 for exactly one cycle, then IDLE.
  - start asserted during FINISH is ignored.
- start outside IDLE is ignored; no queuing.
- Addresses are IN_BASE+index and OUT_BASE+index truncated to AW bits, so they wrap modulo 2^AW.
- busy=1 in LOAD, RUN, DRAIN and FINISH.
- timeout_err and run_cycles hold until the next accepted start (timeout_err) or next job end (run_cycles).

Test Plan:
- Basic job (IN_LEN=4, OUT_LEN=2):
  - Stimulus: start, then bytes 11,22,33,44 back-to-back; core model asserts core_done on the 6th RUN cycle; memory at OUT_BASE holds A5,5A.
  - Required: 4 writes to addresses 0..3; core_reset low for 6 cycles; run_cycles=5; out stream A5,5A; complete pulse one cycle; busy returns to 0.
- Input and output stalls:
  - Stimulus: in_valid toggled 1,0,0,1,…; out_ready held 0 for 3 cycles on the first result byte.
  - Required: writes only on handshakes with no gaps in addresses; out_data and mem_addr stable through the stall.
- Timeout (TIMEOUT=16):
  - Stimulus: core_done never asserted.
  - Required: FINISH after 16 RUN cycles; timeout_err=1; run_cycles=16; no out_valid; complete pulses once.
  - Next start clears timeout_err.
- Simultaneous events:
  - core_done=1 in the same cycle the counter hits TIMEOUT-1: required DRAIN entered, timeout_err=0.
  - start during DRAIN: required to be ignored.
- Reset mid-operation:
  - Stimulus: reset asserted during RUN and again during DRAIN.
  - Required: next cycle state=IDLE, core_reset=1, mem_own=1, no complete pulse; a fresh job then runs correctly.
- Address wrap (AW=8, IN_BASE=254, IN_LEN=4):
  - Required: writes to 254, 255, 0, 1.
